// File: rtl/xosera_spi_target_pkg.sv
// Shared definitions for the Xosera SPI target front end.
//   spi_state_e     : target FSM states
//   SPI_MIN_CLK_DIV : minimum clk cycles per SCK period (fsck <= fclk / 8)
package xosera_spi_target_pkg;

   typedef enum logic [1:0] {
      StWaitIdle = 2'd0,
      StIdle     = 2'd1,
      StActive   = 2'd2
   } spi_state_e;

   localparam int unsigned SPI_MIN_CLK_DIV = 8;

endpackage

// File: rtl/xosera_sync_edge.sv
// N-stage synchronizer with one history flop and rise/fall detection.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_d          : asynchronous input
//   o_level      : synchronized level (last sync stage)
//   o_rise       : synchronized level went 0 -> 1 (one cycle)
//   o_fall       : synchronized level went 1 -> 0 (one cycle)
module xosera_sync_edge #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_hist;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync <= '0;
         r_hist <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
         r_hist <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_hist;
   assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_hist;

endmodule

// File: rtl/xosera_spi_target.sv
// SPI mode-0 target front end, fully synchronous to clk (no SCK-clocked flops).
// Ports:
//   clk, reset      : system clock, asynchronous active-high reset
//   spi_sck_i       : SPI clock (idle low), spi_copi_i: host data, spi_cs_i: select (low)
//   spi_cipo_o      : reply data, MSB first, registered
//   rx_byte_o       : last complete received byte, held across frames
//   rx_valid_o      : strobe, rx_byte_o updated; rx_first_o marks first byte of frame
//   tx_byte_i       : next reply byte, captured when tx_load_o pulses
//   tx_load_o       : strobe, tx_byte_i captured into the reply shifter
//   frame_end_o     : strobe, CS deasserted
//   busy_o          : high while a frame is active
module xosera_spi_target
   import xosera_spi_target_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       spi_sck_i,
   input  logic       spi_copi_i,
   input  logic       spi_cs_i,
   output logic       spi_cipo_o,
   output logic [7:0] rx_byte_o,
   output logic       rx_valid_o,
   output logic       rx_first_o,
   input  logic [7:0] tx_byte_i,
   output logic       tx_load_o,
   output logic       frame_end_o,
   output logic       busy_o
);

   logic w_sck_rise, w_sck_fall, w_unused_sck_level;
   logic w_cs, w_cs_fall, w_unused_cs_rise;
   logic w_copi, w_unused_copi_rise, w_unused_copi_fall;

   xosera_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_d     (spi_sck_i),
      .o_level (w_unused_sck_level),
      .o_rise  (w_sck_rise),
      .o_fall  (w_sck_fall)
   );

   xosera_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_d     (spi_cs_i),
      .o_level (w_cs),
      .o_rise  (w_unused_cs_rise),
      .o_fall  (w_cs_fall)
   );

   // Same depth as sck so the sampled bit lines up with the detected rise.
   xosera_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
      .i_clk   (clk),
      .i_rst   (reset),
      .i_d     (spi_copi_i),
      .o_level (w_copi),
      .o_rise  (w_unused_copi_rise),
      .o_fall  (w_unused_copi_fall)
   );

   spi_state_e r_state, w_state_next;
   logic [2:0] r_bit_cnt, w_bit_cnt_next;
   logic [7:0] r_rx_shift, w_rx_shift_next;
   logic [7:0] r_tx_shift, w_tx_shift_next;
   logic [7:0] r_rx_byte, w_rx_byte_next;
   logic       r_first, w_first_next;
   logic       r_rx_valid, w_rx_valid_next;
   logic       r_rx_first, w_rx_first_next;
   logic       r_tx_load, w_tx_load_next;
   logic       r_frame_end, w_frame_end_next;
   logic       r_cipo, w_cipo_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= StWaitIdle;
         r_bit_cnt   <= 3'd0;
         r_rx_shift  <= 8'h00;
         r_tx_shift  <= 8'h00;
         r_rx_byte   <= 8'h00;
         r_first     <= 1'b0;
         r_rx_valid  <= 1'b0;
         r_rx_first  <= 1'b0;
         r_tx_load   <= 1'b0;
         r_frame_end <= 1'b0;
         r_cipo      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_bit_cnt   <= w_bit_cnt_next;
         r_rx_shift  <= w_rx_shift_next;
         r_tx_shift  <= w_tx_shift_next;
         r_rx_byte   <= w_rx_byte_next;
         r_first     <= w_first_next;
         r_rx_valid  <= w_rx_valid_next;
         r_rx_first  <= w_rx_first_next;
         r_tx_load   <= w_tx_load_next;
         r_frame_end <= w_frame_end_next;
         r_cipo      <= w_cipo_next;
      end
   end

   always_comb begin
      w_state_next     = r_state;
      w_bit_cnt_next   = r_bit_cnt;
      w_rx_shift_next  = r_rx_shift;
      w_tx_shift_next  = r_tx_shift;
      w_rx_byte_next   = r_rx_byte;
      w_first_next     = r_first;
      w_rx_valid_next  = 1'b0;
      w_rx_first_next  = 1'b0;
      w_tx_load_next   = 1'b0;
      w_frame_end_next = 1'b0;

      unique case (r_state)
         // Skip any frame already running when reset releases.
         StWaitIdle: begin
            if (w_cs) w_state_next = StIdle;
         end
         StIdle: begin
            if (w_cs_fall) begin
               w_state_next    = StActive;
               w_tx_shift_next = tx_byte_i;
               w_tx_load_next  = 1'b1;
               w_bit_cnt_next  = 3'd0;
               w_rx_shift_next = 8'h00;
               w_first_next    = 1'b1;
            end
         end
         StActive: begin
            // CS deassert wins over any coincident sck edge; partial byte dropped.
            if (w_cs) begin
               w_state_next     = StIdle;
               w_frame_end_next = 1'b1;
            end else if (w_sck_rise) begin
               w_rx_shift_next = {r_rx_shift[6:0], w_copi};
               w_bit_cnt_next  = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) begin
                  w_rx_byte_next  = {r_rx_shift[6:0], w_copi};
                  w_rx_valid_next = 1'b1;
                  w_rx_first_next = r_first;
                  w_first_next    = 1'b0;
               end
            end else if (w_sck_fall) begin
               // Byte boundary: fetch the next reply, otherwise shift out the next bit.
               if (r_bit_cnt == 3'd0) begin
                  w_tx_shift_next = tx_byte_i;
                  w_tx_load_next  = 1'b1;
               end else begin
                  w_tx_shift_next = {r_tx_shift[6:0], 1'b0};
               end
            end
         end
         default: w_state_next = StWaitIdle;
      endcase

      w_cipo_next = (w_state_next == StActive) ? w_tx_shift_next[7] : 1'b0;
   end

   assign spi_cipo_o  = r_cipo;
   assign rx_byte_o   = r_rx_byte;
   assign rx_valid_o  = r_rx_valid;
   assign rx_first_o  = r_rx_first;
   assign tx_load_o   = r_tx_load;
   assign frame_end_o = r_frame_end;
   assign busy_o      = (r_state == StActive);

endmodule

// File: tb/tb_xosera_spi_target.sv
// Self-checking bench for xosera_spi_target: table-driven frames, randomized frames
// against a byte-level host model, and hand-written corner sequences.
module tb_xosera_spi_target;
   import xosera_spi_target_pkg::*;

   localparam int SYNC = 2;
   localparam int HALF = SPI_MIN_CLK_DIV / 2;
   localparam int CLK_PERIOD = 10;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sck = 1'b0;
   logic       copi = 1'b0;
   logic       cs = 1'b1;
   logic       cipo;
   logic [7:0] rx_byte;
   logic       rx_valid, rx_first, tx_load, frame_end, busy;
   logic [7:0] tx_byte;

   always #(CLK_PERIOD / 2) clk = ~clk;

   xosera_spi_target #(.SYNC_STAGES(SYNC)) dut (
      .clk         (clk),
      .reset       (reset),
      .spi_sck_i   (sck),
      .spi_copi_i  (copi),
      .spi_cs_i    (cs),
      .spi_cipo_o  (cipo),
      .rx_byte_o   (rx_byte),
      .rx_valid_o  (rx_valid),
      .rx_first_o  (rx_first),
      .tx_byte_i   (tx_byte),
      .tx_load_o   (tx_load),
      .frame_end_o (frame_end),
      .busy_o      (busy)
   );

   // Reply source: entry k is presented after the k-th byte of the current frame.
   logic [7:0] reply_tab [8];
   int         reply_base = 0;
   int         rx_seen = 0;
   logic [2:0] rep_idx;
   assign rep_idx = 3'(rx_seen - reply_base);
   assign tx_byte = reply_tab[rep_idx];

   // Monitor (sampled on negedge, away from the active edge).
   logic [7:0] mon_rx_q[$];
   logic       mon_first_q[$];
   int         mon_loads = 0;
   int         mon_ends = 0;
   int         mon_busy_cyc = 0;
   time        t_rx_last = 0;
   time        t_rise_last = 0;
   bit         idle_bad = 1'b0;

   always @(negedge clk) begin
      if (rx_valid) begin
         mon_rx_q.push_back(rx_byte);
         mon_first_q.push_back(rx_first);
         t_rx_last = $time;
         rx_seen = rx_seen + 1;
      end
      if (tx_load) mon_loads = mon_loads + 1;
      if (frame_end) mon_ends = mon_ends + 1;
      if (busy) mon_busy_cyc = mon_busy_cyc + 1;
      if (!busy && cipo) idle_bad = 1'b1;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Host side of one mode-0 frame; cipo captured just before each rising sck.
   task automatic host_frame(input logic [31:0] data, input int nbits, output logic [31:0] got);
      got = '0;
      cs = 1'b0;
      wait_clk(2 * HALF);
      for (int i = 0; i < nbits; i++) begin
         copi = data[31-i];
         wait_clk(HALF);
         got = {got[30:0], cipo};
         sck = 1'b1;
         t_rise_last = $time;
         wait_clk(HALF);
         sck = 1'b0;
      end
      wait_clk(HALF);
      cs = 1'b1;
      copi = 1'b0;
      wait_clk(3 * HALF);
   endtask

   task automatic run_frame(input string tag, input logic [31:0] data, input int nbits,
                            input logic [31:0] reps, input int exp_nrx,
                            input logic [7:0] exp_last, input logic [31:0] exp_read);
      int          rx0, ld0, en0, nfull;
      logic [31:0] got, got_l, mask;
      for (int k = 0; k < 4; k++) reply_tab[k] = reps[31-8*k -: 8];
      reply_base = rx_seen;
      rx0 = mon_rx_q.size();
      ld0 = mon_loads;
      en0 = mon_ends;
      host_frame(data, nbits, got);
      nfull = nbits / 8;
      check({tag, " rx count"}, mon_rx_q.size() - rx0, exp_nrx);
      for (int k = 0; k < exp_nrx && rx0 + k < mon_rx_q.size(); k++) begin
         check({tag, " rx byte"}, mon_rx_q[rx0+k], data[31-8*k -: 8]);
         check({tag, " rx first"}, mon_first_q[rx0+k], (k == 0));
      end
      // One load at CS fall plus one at each byte-boundary sck fall.
      check({tag, " tx loads"}, mon_loads - ld0, 1 + nfull);
      check({tag, " frame end"}, mon_ends - en0, 1);
      check({tag, " rx hold"}, rx_byte, exp_last);
      check({tag, " busy idle"}, busy, 1'b0);
      if (nfull > 0) begin
         got_l = got << (32 - nbits);
         mask = 32'hFFFF_FFFF << (32 - 8 * nfull);
         check({tag, " host read"}, got_l & mask, exp_read & mask);
      end
      if (nfull > 0 && nbits % 8 == 0) begin
         check({tag, " rx latency ok"},
               ((t_rx_last - t_rise_last) >= SYNC * CLK_PERIOD) &&
               ((t_rx_last - t_rise_last) <= (SYNC + 2) * CLK_PERIOD), 1);
      end
   endtask

   typedef struct {
      logic [31:0] data;
      int          nbits;
      logic [31:0] reps;
      int          exp_nrx;
      logic [7:0]  exp_last;
      logic [31:0] exp_read;
   } vec_t;

   initial begin
      vec_t        vecs [4];
      logic [7:0]  model_last;
      logic [31:0] got;
      int          rx0, ld0, en0, bz0;

      for (int k = 0; k < 8; k++) reply_tab[k] = 8'h00;

      // Reset state.
      wait_clk(3);
      check("reset cipo", cipo, 0);
      check("reset rx_byte", rx_byte, 0);
      check("reset rx_valid", rx_valid, 0);
      check("reset rx_first", rx_first, 0);
      check("reset tx_load", tx_load, 0);
      check("reset frame_end", frame_end, 0);
      check("reset busy", busy, 0);
      reset = 1'b0;
      wait_clk(10);

      vecs[0] = '{32'hA500_0000, 8, 32'h3C00_0000, 1, 8'hA5, 32'h3C00_0000};
      // Replies follow rx_byte+1: 0x00 initial, then 0x02, 0x81.
      vecs[1] = '{32'h0180_FF00, 24, 32'h0002_8182, 3, 8'hFF, 32'h0002_8100};
      vecs[2] = '{32'hF800_0000, 5, 32'hAA00_0000, 0, 8'hFF, 32'h0000_0000};
      vecs[3] = '{32'h5A00_0000, 8, 32'h9600_0000, 1, 8'h5A, 32'h9600_0000};
      for (int v = 0; v < 4; v++) begin
         run_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].nbits, vecs[v].reps,
                   vecs[v].exp_nrx, vecs[v].exp_last, vecs[v].exp_read);
      end
      model_last = 8'h5A;

      // CS rise lands on the same clk as the 8th sck rise: frame_end only.
      reply_tab[0] = 8'hE7;
      reply_base = rx_seen;
      rx0 = mon_rx_q.size();
      ld0 = mon_loads;
      en0 = mon_ends;
      cs = 1'b0;
      wait_clk(2 * HALF);
      for (int i = 0; i < 8; i++) begin
         copi = i[0];
         wait_clk(HALF);
         sck = 1'b1;
         if (i == 7) cs = 1'b1;
         wait_clk(HALF);
         sck = 1'b0;
      end
      copi = 1'b0;
      wait_clk(3 * HALF);
      check("coinc rx count", mon_rx_q.size() - rx0, 0);
      check("coinc frame end", mon_ends - en0, 1);
      check("coinc tx loads", mon_loads - ld0, 1);
      check("coinc rx hold", rx_byte, model_last);

      // Randomized frames against the byte-level host model.
      for (int r = 0; r < 24; r++) begin
         logic [31:0] data, reps;
         int          nbits, nfull;
         logic [7:0]  exp_last;
         nbits = 8 * int'($urandom_range(1, 3));
         if ($urandom_range(0, 3) == 0) nbits = nbits - int'($urandom_range(1, 7));
         data = $urandom;
         reps = $urandom;
         nfull = nbits / 8;
         exp_last = (nfull > 0) ? data[31-8*(nfull-1) -: 8] : model_last;
         run_frame($sformatf("rand%0d", r), data, nbits, reps, nfull, exp_last, reps);
         model_last = exp_last;
      end

      // SCK activity with CS high must be ignored.
      rx0 = mon_rx_q.size();
      ld0 = mon_loads;
      en0 = mon_ends;
      bz0 = mon_busy_cyc;
      for (int i = 0; i < 20; i++) begin
         copi = ~copi;
         sck = 1'b1;
         wait_clk(HALF);
         sck = 1'b0;
         wait_clk(HALF);
      end
      check("cs-high rx count", mon_rx_q.size() - rx0, 0);
      check("cs-high tx loads", mon_loads - ld0, 0);
      check("cs-high frame end", mon_ends - en0, 0);
      check("cs-high busy", mon_busy_cyc - bz0, 0);
      check("cs-high cipo", cipo, 0);

      // Reset released while a frame is in progress: nothing decoded until CS high.
      reset = 1'b1;
      cs = 1'b0;
      wait_clk(3);
      reset = 1'b0;
      rx0 = mon_rx_q.size();
      ld0 = mon_loads;
      en0 = mon_ends;
      bz0 = mon_busy_cyc;
      for (int i = 0; i < 11; i++) begin
         copi = ~copi;
         wait_clk(HALF);
         sck = 1'b1;
         wait_clk(HALF);
         sck = 1'b0;
      end
      wait_clk(HALF);
      cs = 1'b1;
      copi = 1'b0;
      wait_clk(3 * HALF);
      check("midrst rx count", mon_rx_q.size() - rx0, 0);
      check("midrst tx loads", mon_loads - ld0, 0);
      check("midrst frame end", mon_ends - en0, 0);
      check("midrst busy", mon_busy_cyc - bz0, 0);
      check("midrst rx_byte", rx_byte, 0);
      run_frame("after midrst", 32'hC300_0000, 8, 32'h6900_0000, 1, 8'hC3, 32'h6900_0000);

      check("cipo low when idle", idle_bad, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
